// File: rtl/etb_trig_router_if.sv
// -----------------------------------------------------------------------------
// etb_trig_router_if
// APB bundle for the ETB trigger router: zero-wait-state APB, 32-bit
// address and data.
//   psel, penable, pwrite : APB control (master -> slave)
//   paddr, pwdata         : APB address / write data (master -> slave)
//   prdata                : APB read data (slave -> master)
// -----------------------------------------------------------------------------
interface etb_trig_router_if;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata
   );
endinterface

// File: rtl/etb_trig_router.sv
// -----------------------------------------------------------------------------
// etb_trig_router
// APB-programmable event trigger router. Each of NCH channels watches one
// source trigger (rising edge) or a software trigger and emits a one-cycle
// "enable on" or "enable off" pulse to one destination timer slot.
//   pclk, presetn      : clock, asynchronous active-low reset
//   apb                : APB slave port (psel/penable/pwrite/paddr/pwdata/prdata)
//   src_trig[NSRC]     : source triggers, rising edge detected
//   dst_trig_en_on     : per-destination one-cycle enable-on pulse
//   dst_trig_en_off    : per-destination one-cycle enable-off pulse
//   intr               : level interrupt, |(STATUS & INTEN)
// Register map (paddr[7:0]): 0x00 CTRL, 0x04 INTEN, 0x08 SWTRIG (wo),
// 0x0C STATUS (w1c), 0x10+4n CHn_CFG {ONESHOT[16], ACT[12], DSTSEL[10:8],
// SRCSEL[6:4], EN[0]}.
// -----------------------------------------------------------------------------
module etb_trig_router #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned NSRC = 8,
   parameter int unsigned NDST = 8
) (
   input  logic             pclk,
   input  logic             presetn,
   etb_trig_router_if.slave apb,
   input  logic [NSRC-1:0]  src_trig,
   output logic [NDST-1:0]  dst_trig_en_on,
   output logic [NDST-1:0]  dst_trig_en_off,
   output logic             intr
);

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_INTEN  = 8'h04;
   localparam logic [7:0] ADDR_SWTRIG = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h0C;

   // ---------------------------------------------------------------------------
   // APB decode
   // ---------------------------------------------------------------------------
   logic           wr_en;
   logic [7:0]     addr;
   logic           sel_ctrl, sel_inten, sel_swtrig, sel_status;
   logic [NCH-1:0] sel_cfg;

   assign wr_en      = apb.psel & apb.penable & apb.pwrite;
   assign addr       = apb.paddr[7:0];
   assign sel_ctrl   = (addr == ADDR_CTRL);
   assign sel_inten  = (addr == ADDR_INTEN);
   assign sel_swtrig = (addr == ADDR_SWTRIG);
   assign sel_status = (addr == ADDR_STATUS);

   always_comb begin
      sel_cfg = '0;
      for (int n = 0; n < NCH; n++) begin
         sel_cfg[n] = (addr == 8'(16 + 4 * n));
      end
   end

   // Only the low address byte and a subset of write-data bits are decoded.
   logic unused_bits;
   assign unused_bits = ^{apb.paddr[31:8], apb.pwdata};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic            gen_q;
   logic [NCH-1:0]  inten_q, status_q, sw_q, fire_q;
   logic [NCH-1:0]  en_q, act_q, oneshot_q;
   logic [2:0]      srcsel_q [NCH];
   logic [2:0]      dstsel_q [NCH];
   logic [NSRC-1:0] src_q, src_q2;
   logic [NDST-1:0] pend_on_q, pend_off_q, on_q, off_q;

   logic [NCH-1:0]  status_d, sw_d, en_d, act_d, oneshot_d;
   logic [2:0]      srcsel_d [NCH];
   logic [2:0]      dstsel_d [NCH];

   // ---------------------------------------------------------------------------
   // Fire decision: one stage after the edge/software-trigger stage
   // ---------------------------------------------------------------------------
   logic [7:0]     src_edge;
   logic [NCH-1:0] fire;
   logic [7:0]     pend_on_w, pend_off_w;

   always_comb begin
      src_edge = '0;
      for (int i = 0; i < NSRC; i++) begin
         src_edge[i] = src_q[i] & ~src_q2[i];
      end
      fire       = '0;
      pend_on_w  = '0;
      pend_off_w = '0;
      for (int n = 0; n < NCH; n++) begin
         // SRCSEL beyond NSRC never matches a hardware edge.
         fire[n] = gen_q & en_q[n] &
                   (((32'(srcsel_q[n]) < NSRC) & src_edge[srcsel_q[n]]) | sw_q[n]);
         // DSTSEL beyond NDST still fires (STATUS) but drives nothing.
         if (fire[n] && (32'(dstsel_q[n]) < NDST)) begin
            if (act_q[n]) pend_off_w[dstsel_q[n]] = 1'b1;
            else          pend_on_w[dstsel_q[n]]  = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      status_d = status_q;
      if (wr_en && sel_status) status_d = status_q & ~apb.pwdata[NCH-1:0];
      // A coincident set beats the write-1-to-clear.
      status_d = status_d | fire_q;

      // Software triggers are dropped entirely while globally disabled.
      sw_d = (wr_en && sel_swtrig && gen_q) ? apb.pwdata[NCH-1:0] : '0;

      en_d      = en_q & ~(fire & oneshot_q);
      act_d     = act_q;
      oneshot_d = oneshot_q;
      srcsel_d  = srcsel_q;
      dstsel_d  = dstsel_q;
      for (int n = 0; n < NCH; n++) begin
         // A CFG write landing on the one-shot fire edge takes priority.
         if (wr_en && sel_cfg[n]) begin
            en_d[n]      = apb.pwdata[0];
            srcsel_d[n]  = apb.pwdata[6:4];
            dstsel_d[n]  = apb.pwdata[10:8];
            act_d[n]     = apb.pwdata[12];
            oneshot_d[n] = apb.pwdata[16];
         end
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         gen_q      <= 1'b0;
         inten_q    <= '0;
         status_q   <= '0;
         sw_q       <= '0;
         fire_q     <= '0;
         en_q       <= '0;
         act_q      <= '0;
         oneshot_q  <= '0;
         src_q      <= '0;
         src_q2     <= '0;
         pend_on_q  <= '0;
         pend_off_q <= '0;
         on_q       <= '0;
         off_q      <= '0;
         for (int n = 0; n < NCH; n++) begin
            srcsel_q[n] <= '0;
            dstsel_q[n] <= '0;
         end
      end else begin
         if (wr_en && sel_ctrl)  gen_q   <= apb.pwdata[0];
         if (wr_en && sel_inten) inten_q <= apb.pwdata[NCH-1:0];
         status_q   <= status_d;
         sw_q       <= sw_d;
         en_q       <= en_d;
         act_q      <= act_d;
         oneshot_q  <= oneshot_d;
         srcsel_q   <= srcsel_d;
         dstsel_q   <= dstsel_d;
         // Edge detector keeps sampling regardless of GEN so no edge is replayed.
         src_q      <= src_trig;
         src_q2     <= src_q;
         fire_q     <= fire;
         pend_on_q  <= pend_on_w[NDST-1:0];
         pend_off_q <= pend_off_w[NDST-1:0];
         // Off wins over on for the same destination.
         on_q       <= pend_on_q & ~pend_off_q;
         off_q      <= pend_off_q;
      end
   end

   assign dst_trig_en_on  = on_q;
   assign dst_trig_en_off = off_q;
   assign intr            = |(status_q & inten_q);

   // ---------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      if (apb.psel) begin
         if (sel_ctrl)   rdata = {31'b0, gen_q};
         if (sel_inten)  rdata = 32'(inten_q);
         if (sel_status) rdata = 32'(status_q);
         for (int n = 0; n < NCH; n++) begin
            if (sel_cfg[n]) begin
               rdata = {15'b0, oneshot_q[n], 3'b0, act_q[n], 1'b0, dstsel_q[n],
                        1'b0, srcsel_q[n], 3'b0, en_q[n]};
            end
         end
      end
   end

   assign apb.prdata = rdata;

endmodule

// File: tb/tb_etb_trig_router.sv
module tb_etb_trig_router;
   localparam int unsigned NCH  = 4;
   localparam int unsigned NSRC = 8;
   localparam int unsigned NDST = 8;

   logic            pclk = 1'b0;
   logic            presetn = 1'b0;
   logic [NSRC-1:0] src_trig = '0;
   logic [NDST-1:0] dst_on, dst_off;
   logic            intr;
   int              n_checks = 0;
   int              n_fail = 0;

   etb_trig_router_if apb ();

   etb_trig_router #(.NCH(NCH), .NSRC(NSRC), .NDST(NDST)) dut (
      .pclk            (pclk),
      .presetn         (presetn),
      .apb             (apb),
      .src_trig        (src_trig),
      .dst_trig_en_on  (dst_on),
      .dst_trig_en_off (dst_off),
      .intr            (intr)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Write returns at the negedge just after the commit edge.
   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      @(negedge pclk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
      apb.paddr = {24'h0, a}; apb.pwdata = d;
      @(negedge pclk);
      apb.penable = 1'b1;
      @(negedge pclk);
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      @(negedge pclk);
      apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = {24'h0, a};
      #1 d = apb.prdata;
      apb.psel = 1'b0;
   endtask

   task automatic test_reset;
      logic [31:0] rd;
      #1;
      n_checks++;
      if ({dst_on, dst_off, intr} !== '0) begin
         n_fail++; $display("FAIL reset_out got=%h/%h/%b exp=0", dst_on, dst_off, intr);
      end
      repeat (3) @(negedge pclk);
      presetn = 1'b1;
      for (int a = 0; a < 32; a += 4) begin
         apb_read(8'(a), rd);
         n_checks++;
         if (rd !== 32'h0) begin
            n_fail++; $display("FAIL reset_reg addr=%h got=%h exp=0", a, rd);
         end
      end
   endtask

   task automatic test_basic;
      logic [31:0] rd;
      apb_write(8'h00, 32'h1);
      apb_write(8'h04, 32'h1);
      apb_write(8'h10, 32'h0000_0201);
      @(negedge pclk); src_trig[0] = 1'b1;
      @(negedge pclk); src_trig[0] = 1'b0;
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h00) begin
         n_fail++; $display("FAIL basic_early got=%h exp=00", dst_on);
      end
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h04 || dst_off !== 8'h00) begin
         n_fail++; $display("FAIL basic_pulse got=%h/%h exp=04/00", dst_on, dst_off);
      end
      n_checks++;
      if (intr !== 1'b1) begin
         n_fail++; $display("FAIL basic_intr got=%b exp=1", intr);
      end
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h00) begin
         n_fail++; $display("FAIL basic_width got=%h exp=00", dst_on);
      end
      apb_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'h1) begin
         n_fail++; $display("FAIL basic_status got=%h exp=1", rd);
      end
      apb_write(8'h0C, 32'h1);
      n_checks++;
      if (intr !== 1'b0) begin
         n_fail++; $display("FAIL basic_w1c_intr got=%b exp=0", intr);
      end
   endtask

   task automatic test_level_hold;
      int cnt;
      apb_write(8'h14, 32'h0000_1031);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge pclk);
         if (dst_off[0] === 1'b1) cnt++;
         src_trig[3] = (i < 20);
      end
      n_checks++;
      if (cnt != 1) begin
         n_fail++; $display("FAIL level_hold pulses got=%0d exp=1", cnt);
      end
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         if (dst_off[0] === 1'b1) cnt++;
         src_trig[3] = 1'b1;
      end
      src_trig[3] = 1'b0;
      n_checks++;
      if (cnt != 1) begin
         n_fail++; $display("FAIL level_rerise pulses got=%0d exp=1", cnt);
      end
   endtask

   task automatic test_conflict;
      logic [31:0] rd;
      apb_write(8'h10, 32'h0000_0101);
      apb_write(8'h14, 32'h0000_1101);
      apb_write(8'h0C, 32'hF);
      apb_write(8'h08, 32'h3);
      @(negedge pclk);
      n_checks++;
      if ({dst_on, dst_off} !== 16'h0) begin
         n_fail++; $display("FAIL conflict_early got=%h/%h exp=00/00", dst_on, dst_off);
      end
      @(negedge pclk);
      n_checks++;
      if (dst_off !== 8'h02 || dst_on !== 8'h00) begin
         n_fail++; $display("FAIL conflict_pulse got on=%h off=%h exp on=00 off=02",
                            dst_on, dst_off);
      end
      apb_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'h3) begin
         n_fail++; $display("FAIL conflict_status got=%h exp=3", rd);
      end
   endtask

   task automatic test_oneshot;
      logic [31:0] rd;
      int cnt;
      apb_write(8'h10, 32'h0);
      apb_write(8'h14, 32'h0);
      apb_write(8'h0C, 32'hF);
      apb_write(8'h18, 32'h0001_0011);
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge pclk);
         if (dst_on[0] === 1'b1) cnt++;
         src_trig[1] = (i == 0 || i == 5);
      end
      n_checks++;
      if (cnt != 1) begin
         n_fail++; $display("FAIL oneshot_pulses got=%0d exp=1", cnt);
      end
      apb_read(8'h18, rd);
      n_checks++;
      if (rd !== 32'h0001_0010) begin
         n_fail++; $display("FAIL oneshot_cfg got=%h exp=00010010", rd);
      end
      apb_write(8'h08, 32'h4);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge pclk);
         if ({dst_on, dst_off} !== 16'h0) cnt++;
      end
      n_checks++;
      if (cnt != 0) begin
         n_fail++; $display("FAIL oneshot_sw_disabled pulses got=%0d exp=0", cnt);
      end
   endtask

   task automatic test_gen_disable;
      logic [31:0] rd;
      int cnt;
      apb_write(8'h10, 32'h0000_0201);
      apb_write(8'h00, 32'h0);
      apb_write(8'h0C, 32'hF);
      apb_write(8'h08, 32'hF);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge pclk);
         if ({dst_on, dst_off} !== 16'h0) cnt++;
         src_trig = (i == 2) ? 8'hFF : 8'h00;
      end
      n_checks++;
      if (cnt != 0) begin
         n_fail++; $display("FAIL gen_off_pulses got=%0d exp=0", cnt);
      end
      apb_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++; $display("FAIL gen_off_status got=%h exp=0", rd);
      end
      apb_write(8'h00, 32'h1);
      apb_write(8'h08, 32'h1);
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h00) begin
         n_fail++; $display("FAIL gen_on_early got=%h exp=00", dst_on);
      end
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h04) begin
         n_fail++; $display("FAIL gen_on_pulse got=%h exp=04", dst_on);
      end
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h00) begin
         n_fail++; $display("FAIL gen_on_width got=%h exp=00", dst_on);
      end
   endtask

   task automatic test_reset_mid_pulse;
      logic [31:0] rd;
      apb_write(8'h04, 32'h1);
      apb_write(8'h08, 32'h1);
      @(negedge pclk);
      @(negedge pclk);
      n_checks++;
      if (dst_on !== 8'h04 || intr !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre got=%h/%b exp=04/1", dst_on, intr);
      end
      #1 presetn = 1'b0;
      apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = 32'h0C;
      #1;
      n_checks++;
      if ({dst_on, dst_off, intr} !== '0 || apb.prdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_async got=%h/%h/%b/%h exp=0", dst_on, dst_off, intr,
                            apb.prdata);
      end
      apb.paddr = 32'h10;
      #1;
      n_checks++;
      if (apb.prdata !== 32'h0) begin
         n_fail++; $display("FAIL rst_cfg got=%h exp=0", apb.prdata);
      end
      apb.psel = 1'b0;
      @(negedge pclk); @(negedge pclk);
      presetn = 1'b1;
      for (int a = 0; a < 32; a += 4) begin
         apb_read(8'(a), rd);
         n_checks++;
         if (rd !== 32'h0) begin
            n_fail++; $display("FAIL rst_release addr=%h got=%h exp=0", a, rd);
         end
      end
   endtask

   // Randomized traffic against a scheduled-event model: an event seen at
   // edge i (source rising edge or committed SWTRIG) appears at edge i+2.
   task automatic test_random;
      localparam int N = 400;
      logic [31:0]     rd;
      bit              m_en [NCH], m_act [NCH], m_os [NCH];
      bit [2:0]        m_src [NCH], m_dst [NCH];
      bit [NCH-1:0]    m_status, m_inten, sw, sw_commit, set_v;
      bit [NDST-1:0]   exp_on [N+4], exp_off [N+4], on_v, off_v;
      bit [NCH-1:0]    exp_set [N+4];
      bit [NSRC-1:0]   cur_src, prev_src, rising;
      int              ph;
      for (int i = 0; i < N + 4; i++) begin
         exp_on[i] = '0; exp_off[i] = '0; exp_set[i] = '0;
      end
      apb_write(8'h00, 32'h1);
      for (int n = 0; n < NCH; n++) begin
         m_en[n]  = ($urandom_range(0, 3) != 0);
         m_src[n] = 3'($urandom_range(0, 7));
         m_dst[n] = 3'($urandom_range(0, 7));
         m_act[n] = 1'($urandom_range(0, 1));
         m_os[n]  = ($urandom_range(0, 3) == 0);
         apb_write(8'(16 + 4 * n), {15'b0, m_os[n], 3'b0, m_act[n], 1'b0, m_dst[n],
                                    1'b0, m_src[n], 3'b0, m_en[n]});
      end
      m_inten = NCH'($urandom);
      apb_write(8'h04, 32'(m_inten));
      apb_write(8'h0C, 32'hF);
      repeat (3) @(negedge pclk);
      m_status = '0; cur_src = '0; prev_src = '0; sw_commit = '0; ph = 0;
      for (int i = 0; i < N; i++) begin
         @(negedge pclk);
         m_status |= exp_set[i];
         n_checks++;
         if (dst_on !== exp_on[i] || dst_off !== exp_off[i]) begin
            n_fail++; $display("FAIL rnd_out cyc=%0d got=%h/%h exp=%h/%h", i, dst_on, dst_off,
                               exp_on[i], exp_off[i]);
         end
         n_checks++;
         if (intr !== |(m_status & m_inten)) begin
            n_fail++; $display("FAIL rnd_intr cyc=%0d got=%b exp=%b", i, intr,
                               |(m_status & m_inten));
         end
         rising = cur_src & ~prev_src;
         prev_src = cur_src;
         sw = sw_commit;
         sw_commit = '0;
         on_v = '0; off_v = '0; set_v = '0;
         for (int n = 0; n < NCH; n++) begin
            if (m_en[n] && ((int'(m_src[n]) < NSRC && rising[m_src[n]]) || sw[n])) begin
               set_v[n] = 1'b1;
               if (int'(m_dst[n]) < NDST) begin
                  if (m_act[n]) off_v[m_dst[n]] = 1'b1;
                  else          on_v[m_dst[n]]  = 1'b1;
               end
               if (m_os[n]) m_en[n] = 1'b0;
            end
         end
         exp_on[i+2]  = on_v & ~off_v;
         exp_off[i+2] = off_v;
         exp_set[i+2] = set_v;
         if (i < N - 10 && $urandom_range(0, 3) == 0) cur_src = NSRC'($urandom);
         src_trig = cur_src;
         case (ph)
            0: if (i < N - 10 && $urandom_range(0, 5) == 0) begin
                  apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
                  apb.paddr = 32'h08; apb.pwdata = $urandom;
                  ph = 1;
               end
            1: begin
                  apb.penable = 1'b1;
                  sw_commit = apb.pwdata[NCH-1:0];
                  ph = 2;
               end
            default: begin
                  apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
                  ph = 0;
               end
         endcase
      end
      apb_read(8'h0C, rd);
      n_checks++;
      if (rd !== 32'(m_status)) begin
         n_fail++; $display("FAIL rnd_status got=%h exp=%h", rd, m_status);
      end
      for (int n = 0; n < NCH; n++) begin
         apb_read(8'(16 + 4 * n), rd);
         n_checks++;
         if (rd !== {15'b0, m_os[n], 3'b0, m_act[n], 1'b0, m_dst[n], 1'b0, m_src[n], 3'b0,
                     m_en[n]}) begin
            n_fail++; $display("FAIL rnd_cfg ch=%0d got=%h en_exp=%b", n, rd, m_en[n]);
         end
      end
   endtask

   initial begin
      apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
      apb.paddr = '0; apb.pwdata = '0;
      test_reset();
      test_basic();
      test_level_hold();
      test_conflict();
      test_oneshot();
      test_gen_disable();
      test_reset_mid_pulse();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
